// File: rtl/post_period.sv
// Post-level countdown: shows "PAS<d>" for POST_SECONDS one-second ticks after a start request,
// then blanks the display and pulses levelComplete for one cycle.
module post_period #(
   parameter int unsigned POST_SECONDS = 3
) (
   input  logic       Clk100M,
   input  logic       Rst_n,
   input  logic       Clk1Hz,
   input  logic       postSig,
   output logic       levelComplete,
   output logic [7:0] postSeg3,
   output logic [7:0] postSeg2,
   output logic [7:0] postSeg1,
   output logic [7:0] postSeg0
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [3:0] RemInit = 4'(POST_SECONDS);
   localparam logic [7:0] SegBlank = 8'hFF;
   localparam logic [7:0] SegP = 8'h8C;
   localparam logic [7:0] SegA = 8'h88;
   localparam logic [7:0] SegS = 8'h92;

   state_e     state_q, state_d;
   logic [3:0] rem_q, rem_d;
   logic       done_d;
   logic [7:0] seg3_d, seg2_d, seg1_d, seg0_d;

   function automatic logic [7:0] digit_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = SegBlank;
      endcase
      return s;
   endfunction

   always_ff @(posedge Clk100M or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q       <= StIdle;
         rem_q         <= 4'd0;
         levelComplete <= 1'b0;
         postSeg3      <= SegBlank;
         postSeg2      <= SegBlank;
         postSeg1      <= SegBlank;
         postSeg0      <= SegBlank;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         levelComplete <= done_d;
         postSeg3      <= seg3_d;
         postSeg2      <= seg2_d;
         postSeg1      <= seg1_d;
         postSeg0      <= seg0_d;
      end
   end

   // A tick coinciding with the start request is dropped: IDLE never looks at Clk1Hz.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (postSig) begin
               state_d = StRun;
               rem_d   = RemInit;
            end
         end
         StRun: begin
            if (Clk1Hz) begin
               if (rem_q > 4'd1) begin
                  rem_d = rem_q - 4'd1;
               end else begin
                  rem_d   = 4'd0;
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Display is derived from the next state so it changes on the same edge as the counter.
   always_comb begin
      seg3_d = SegBlank;
      seg2_d = SegBlank;
      seg1_d = SegBlank;
      seg0_d = SegBlank;
      if (state_d == StRun) begin
         seg3_d = SegP;
         seg2_d = SegA;
         seg1_d = SegS;
         seg0_d = digit_seg(rem_d);
      end
   end

endmodule

// File: tb/tb_post_period.sv
// Scoreboard bench for post_period: a default (3 s) and a 1 s instance share all stimulus.
module tb_post_period;

   logic       Clk100M = 1'b0;
   logic       Rst_n;
   logic       Clk1Hz;
   logic       postSig;
   logic       lc3, lc1;
   logic [7:0] a3, a2, a1, a0;
   logic [7:0] b3, b2, b1, b0;

   post_period #(.POST_SECONDS(3)) dut3 (
      .Clk100M(Clk100M), .Rst_n(Rst_n), .Clk1Hz(Clk1Hz), .postSig(postSig),
      .levelComplete(lc3), .postSeg3(a3), .postSeg2(a2), .postSeg1(a1), .postSeg0(a0)
   );

   post_period #(.POST_SECONDS(1)) dut1 (
      .Clk100M(Clk100M), .Rst_n(Rst_n), .Clk1Hz(Clk1Hz), .postSig(postSig),
      .levelComplete(lc1), .postSeg3(b3), .postSeg2(b2), .postSeg1(b1), .postSeg0(b0)
   );

   always #5 Clk100M = ~Clk100M;

   typedef struct {
      int          d;
      logic [32:0] v;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   bit          m_run[2];
   int          m_rem[2];
   int          ps[2] = '{3, 1};
   logic [7:0]  digits[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   int          cnt3, cnt1, lc3_cyc, lc1_cyc;
   logic [7:0]  prev3, prev1;
   logic [7:0]  seq3[$];
   logic [7:0]  seq1[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] dut_val(input int d);
      return (d == 0) ? {lc3, a3, a2, a1, a0} : {lc1, b3, b2, b1, b0};
   endfunction

   // Reference behaviour for one clock edge with the given inputs.
   function automatic logic [32:0] model_step(input int d, input logic p, input logic t);
      logic lc;
      lc = 1'b0;
      if (!Rst_n) begin
         m_run[d] = 1'b0;
         m_rem[d] = 0;
      end else if (!m_run[d]) begin
         if (p) begin
            m_run[d] = 1'b1;
            m_rem[d] = ps[d];
         end
      end else if (t) begin
         if (m_rem[d] > 1) begin
            m_rem[d] = m_rem[d] - 1;
         end else begin
            m_rem[d] = 0;
            m_run[d] = 1'b0;
            lc       = 1'b1;
         end
      end
      if (!m_run[d]) return {lc, 32'hFFFF_FFFF};
      return {lc, 8'h8C, 8'h88, 8'h92, digits[m_rem[d]]};
   endfunction

   task automatic begin_scn();
      cnt3 = 0; cnt1 = 0; lc3_cyc = -1; lc1_cyc = -1;
      prev3 = 8'hFF; prev1 = 8'hFF;
      seq3.delete(); seq1.delete();
   endtask

   task automatic step(input logic p, input logic t, input int i);
      exp_t e;
      @(negedge Clk100M);
      postSig = p;
      Clk1Hz  = t;
      for (int d = 0; d < 2; d++) begin
         e.d = d;
         e.v = model_step(d, p, t);
         sb.push_back(e);
      end
      @(posedge Clk100M);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("out%0d_c%0d", e.d, i), 64'(dut_val(e.d)), 64'(e.v));
      end
      if (lc3 === 1'b1) begin cnt3++; lc3_cyc = i; end
      if (lc1 === 1'b1) begin cnt1++; lc1_cyc = i; end
      if (a0 !== prev3) seq3.push_back(a0);
      if (b0 !== prev1) seq1.push_back(b0);
      prev3 = a0;
      prev1 = b0;
   endtask

   task automatic run(input int n, input int tper, input int toff,
                      input int pa, input int pb, input int pc);
      for (int i = 0; i < n; i++) begin
         step((i == pa) || (i == pb) || (i == pc), (i % tper) == toff, i);
      end
      postSig = 1'b0;
      Clk1Hz  = 1'b0;
   endtask

   function automatic logic [31:0] seq4(input int d);
      if (d == 0) return (seq3.size() == 4) ? {seq3[0], seq3[1], seq3[2], seq3[3]} : 32'h0;
      return (seq1.size() == 2) ? {16'h0, seq1[0], seq1[1]} : 32'h0;
   endfunction

   initial begin
      Rst_n   = 1'b0;
      postSig = 1'b0;
      Clk1Hz  = 1'b0;
      m_run   = '{1'b0, 1'b0};
      m_rem   = '{0, 0};
      #12;
      check("reset3", 64'(dut_val(0)), {31'h0, 1'b0, 32'hFFFF_FFFF});
      check("reset1", 64'(dut_val(1)), {31'h0, 1'b0, 32'hFFFF_FFFF});
      @(negedge Clk100M);
      Rst_n = 1'b1;

      // Basic countdown, tick every 100 cycles, start at cycle 1.
      begin_scn();
      run(310, 100, 99, 1, -1, -1);
      check("basic_seq3", 64'(seq4(0)), 64'h0000_0000_B0A4_F9FF);
      check("basic_cnt3", 64'(cnt3), 64'd1);
      check("basic_lc3_at", 64'(lc3_cyc), 64'd299);
      check("one_sec_seq1", 64'(seq4(1)), 64'h0000_0000_0000_F9FF);
      check("one_sec_lc1_at", 64'(lc1_cyc), 64'd99);

      // Start coincident with a tick: that tick is ignored.
      begin_scn();
      run(80, 20, 0, 0, -1, -1);
      check("coinc_lc3_at", 64'(lc3_cyc), 64'd60);
      check("coinc_cnt3", 64'(cnt3), 64'd1);
      check("coinc_lc1_at", 64'(lc1_cyc), 64'd20);

      // Extra starts during RUN, one of them on a tick edge.
      begin_scn();
      run(45, 10, 9, 2, 15, 29);
      check("extra_lc3_at", 64'(lc3_cyc), 64'd29);
      check("extra_cnt3", 64'(cnt3), 64'd1);

      // Asynchronous reset after the first tick aborts the period.
      begin_scn();
      run(25, 20, 19, 1, -1, -1);
      #2;
      Rst_n = 1'b0;
      #1;
      check("abort3", 64'(dut_val(0)), {31'h0, 1'b0, 32'hFFFF_FFFF});
      check("abort1", 64'(dut_val(1)), {31'h0, 1'b0, 32'hFFFF_FFFF});
      m_run = '{1'b0, 1'b0};
      m_rem = '{0, 0};
      run(5, 2, 1, 2, -1, -1);
      check("abort_cnt3", 64'(cnt3), 64'd0);
      @(negedge Clk100M);
      Rst_n = 1'b1;
      begin_scn();
      run(70, 20, 19, 3, -1, -1);
      check("restart_seq3", 64'(seq4(0)), 64'h0000_0000_B0A4_F9FF);
      check("restart_lc3_at", 64'(lc3_cyc), 64'd59);

      // Ticks without any start request.
      begin_scn();
      run(50, 5, 4, -1, -1, -1);
      check("idle_cnt3", 64'(cnt3), 64'd0);
      check("idle_cnt1", 64'(cnt1), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/post_period.md
POST_PERIOD -- requirements
Module: post_period

Interface
REQ-001 Parameter POST_SECONDS, default 3, meaning: number of Clk1Hz ticks the post-level message is shown; legal range 1..9.
REQ-002 Clk100M  input  1  system clock; all logic SHALL be clocked on its rising edge; the block has one clock.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Clk1Hz  input  1  once-per-second enable, high for exactly one Clk100M cycle per tick; it SHALL NOT be used as a clock.
REQ-005 postSig  input  1  start request, one-cycle pulse, begins the post period.
REQ-006 levelComplete  output  1  one-cycle pulse marking the end of the post period.
REQ-007 postSeg3..postSeg0  output  8 each  seven-segment patterns, postSeg3 leftmost; bit0..bit6 = segments a..g, bit7 = dp; active-low (0 = lit).

Function
REQ-008 The block SHALL have two states: IDLE and RUN.
REQ-009 In IDLE, a rising Clk100M edge with postSig=1 SHALL load remaining-seconds counter rem <= POST_SECONDS and enter RUN.
REQ-010 A Clk1Hz pulse on the same edge that accepts postSig SHALL be ignored; the first counted tick is the next Clk1Hz pulse, so the first second may be partial.
REQ-011 In RUN, postSig SHALL be ignored, with no restart and no counter reload.
REQ-012 In RUN, on an edge with Clk1Hz=1 and rem>1: rem <= rem-1 and the state stays RUN.
REQ-013 In RUN, on an edge with Clk1Hz=1 and rem==1: rem <= 0, state <= IDLE, levelComplete <= 1, and all postSeg outputs <= blank, all on that same edge.
REQ-014 levelComplete SHALL be registered and high for exactly one Clk100M cycle per completed post period; otherwise 0.
REQ-015 The outputs SHALL be registered and updated on the same edge as the state or counter change (latency 1 cycle from the sampled input).
REQ-016 In RUN the display SHALL read "PAS<d>": postSeg3=8'h8C ('P'), postSeg2=8'h88 ('A'), postSeg1=8'h92 ('S'), postSeg0=digit rem.
REQ-017 Digit encodings (active-low, dp off): 1=8'hF9, 2=8'hA4, 3=8'hB0, 4=8'h99, 5=8'h92, 6=8'h82, 7=8'hF8, 8=8'h80, 9=8'h90.
REQ-018 In IDLE all four postSeg outputs SHALL be blank (8'hFF).
REQ-019 rem SHALL be 4 bits wide and SHALL never underflow below 0.
REQ-020 When Clk1Hz=0, the state, rem and outputs SHALL hold their values.
REQ-021 postSig and Clk1Hz high together in RUN: only the tick SHALL take effect.

Reset
REQ-022 Rst_n=0 SHALL immediately force: state=IDLE, rem=0, levelComplete=0, postSeg0..3=8'hFF.
REQ-023 Deassertion of Rst_n SHALL take effect at the next Clk100M edge.
REQ-024 Reset asserted mid-RUN SHALL abort the period with no levelComplete pulse.

Verification
REQ-025 Clk1Hz pulse every 100 cycles, postSig at cycle 1, POST_SECONDS=3 -> display shows P,A,S,3 then 2 then 1 on successive ticks; exactly one levelComplete pulse on the 3rd tick edge; display then blank.
REQ-026 postSig coincident with a Clk1Hz pulse in IDLE -> postSeg0 stays 8'hB0 through that edge; three further ticks are needed before levelComplete.
REQ-027 Extra postSig pulses during RUN -> countdown and completion timing unchanged; exactly one levelComplete.
REQ-028 Rst_n pulled low after the 1st tick of RUN -> outputs immediately 8'hFF, levelComplete never asserts; a later postSig restarts from 3.
REQ-029 POST_SECONDS=1 -> postSeg0=8'hF9 after start; levelComplete on the first counted tick.
REQ-030 Clk1Hz pulses with no postSig -> outputs remain 8'hFF and levelComplete stays 0 indefinitely.
